mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_sat_cnt.sv | 27 ++
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding, grant
// selector and the starvation counter width.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_D = 3'd1,
    BUSY_I = 3'd2,
    RESP_D = 3'd3,
    RESP_I = 3'd4
  } arb_state_t;

  typedef enum logic {
    GNT_D = 1'b0,
    GNT_I = 1'b1
  } grant_t;

  // STARVE_LIMIT is at most 15, so four bits always hold it.
  localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_arb_sat_cnt.sv
// Saturating up-counter with synchronous clear. Clear wins over increment;
// the count sticks at LIMIT once reached.
module mem_arb_sat_cnt #(
  parameter int unsigned       WIDTH = 4,
  parameter logic [WIDTH-1:0]  LIMIT = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  // Count register: clear, else increment until LIMIT.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o < LIMIT)) begin
      cnt_o <= cnt_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single external memory port between instruction fetch
// and the MEM-stage data access. Data has priority; fetch is forced after
// STARVE_LIMIT consecutive data grants made while fetch was waiting.
// Optional feature macro: MEM_ARB_PERF_EN adds perf_dwait_o / perf_iwait_o
// wait-cycle counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // fetch side
  input  logic                ireq_i,
  input  logic [ADDR_W-1:0]   iaddr_i,
  output logic                iready_o,
  output logic [DATA_W-1:0]   irdata_o,
  // data side
  input  logic                dreq_i,
  input  logic                dwe_i,
  input  logic [ADDR_W-1:0]   daddr_i,
  input  logic [DATA_W-1:0]   dwdata_i,
  input  logic [DATA_W/8-1:0] dwstrb_i,
  output logic                dready_o,
  output logic [DATA_W-1:0]   drdata_o,
  // memory port
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_dwait_o,
  output logic [31:0]         perf_iwait_o
`endif
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

  arb_state_t              state_q, state_d;
  logic                    gnt_en;
  grant_t                  gnt_sel;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    starve_inc, starve_clr;

  logic                    we_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [DATA_W/8-1:0]     wstrb_q;
  logic [DATA_W-1:0]       drdata_q, irdata_q;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and grant decision; grants happen only in IDLE.
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    gnt_en  = 1'b0;
    gnt_sel = GNT_D;
    unique case (state_q)
      IDLE: begin
        if (dreq_i && ((starve_cnt < STARVE_MAX) || !ireq_i)) begin
          state_d = BUSY_D;
          gnt_en  = 1'b1;
          gnt_sel = GNT_D;
        end else if (ireq_i) begin
          state_d = BUSY_I;
          gnt_en  = 1'b1;
          gnt_sel = GNT_I;
        end
      end
      BUSY_D:  if (mem_ack_i) state_d = RESP_D;
      BUSY_I:  if (mem_ack_i) state_d = RESP_I;
      RESP_D,
      RESP_I:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and the latched transaction only, so nothing
  // on the memory port depends combinationally on the request inputs.
  always_comb begin
    mem_req_o   = (state_q == BUSY_D) || (state_q == BUSY_I);
    mem_we_o    = we_q;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    mem_wstrb_o = wstrb_q;
    dready_o    = (state_q == RESP_D);
    iready_o    = (state_q == RESP_I);
    drdata_o    = drdata_q;
    irdata_o    = irdata_q;
  end

  // Capture the granted requester's fields; a fetch is always a plain read.
  // NOTE: these datapath flops are reset too, because their values are
  // visible on the memory port outputs straight out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (gnt_en) begin
      if (gnt_sel == GNT_D) begin
        we_q    <= dwe_i;
        addr_q  <= daddr_i;
        wdata_q <= dwdata_i;
        wstrb_q <= dwstrb_i;
      end else begin
        we_q    <= 1'b0;
        addr_q  <= iaddr_i;
        wdata_q <= '0;
        wstrb_q <= '0;
      end
    end
  end

  // Load / fetch data registers; a store leaves drdata untouched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drdata_q <= '0;
      irdata_q <= '0;
    end else if (mem_ack_i) begin
      if (state_q == BUSY_D && !we_q) drdata_q <= mem_rdata_i;
      if (state_q == BUSY_I)          irdata_q <= mem_rdata_i;
    end
  end

  // Starvation tracking: count data grants taken while fetch waits.
  always_comb begin
    starve_inc = gnt_en && (gnt_sel == GNT_D) && ireq_i;
    starve_clr = (gnt_en && (gnt_sel == GNT_I)) || ((state_q == IDLE) && !ireq_i);
  end

  mem_arb_sat_cnt #(
    .WIDTH (STARVE_CNT_W),
    .LIMIT (STARVE_MAX)
  ) u_starve_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (starve_inc),
    .clr_i  (starve_clr),
    .cnt_o  (starve_cnt)
  );

`ifdef MEM_ARB_PERF_EN
  // Wait-cycle counters: requester asserted but not yet answered.
  mem_arb_sat_cnt #(
    .WIDTH (32)
  ) u_perf_dwait (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (dreq_i && !dready_o),
    .clr_i  (1'b0),
    .cnt_o  (perf_dwait_o)
  );

  mem_arb_sat_cnt #(
    .WIDTH (32)
  ) u_perf_iwait (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (ireq_i && !iready_o),
    .clr_i  (1'b0),
    .cnt_o  (perf_iwait_o)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A bench-owned memory answers the
// port with a programmable wait; a transaction-level model predicts grant
// order, completion times and data. Perf checks are built when
// MEM_ARB_PERF_EN is defined.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int          TIMEOUT      = 2000;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  typedef struct packed {
    logic is_i;
    txn_t t;
  } exp_t;

  logic        clk, rst_ni;
  logic        ireq_i, iready_o;
  logic [31:0] iaddr_i, irdata_o;
  logic        dreq_i, dwe_i, dready_o;
  logic [31:0] daddr_i, dwdata_i, drdata_o;
  logic [3:0]  dwstrb_i;
  logic        mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_wstrb_o;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_dwait_o, perf_iwait_o;
`endif

  int          n_cmp = 0;
  int          n_fail = 0;
  int          mem_wait = 0;
  bit          stray_ack = 0;
  logic [31:0] mem     [0:255];
  logic [31:0] exp_mem [0:255];
  logic [31:0] exp_d_last = '0;
  txn_t        acc_log[$];
  txn_t        d_plan[$];
  txn_t        i_plan[$];

  mem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .ireq_i      (ireq_i),
    .iaddr_i     (iaddr_i),
    .iready_o    (iready_o),
    .irdata_o    (irdata_o),
    .dreq_i      (dreq_i),
    .dwe_i       (dwe_i),
    .daddr_i     (daddr_i),
    .dwdata_i    (dwdata_i),
    .dwstrb_i    (dwstrb_i),
    .dready_o    (dready_o),
    .drdata_o    (drdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wstrb_o (mem_wstrb_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_dwait_o (perf_dwait_o),
    .perf_iwait_o (perf_iwait_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  // Memory: acks after mem_wait idle cycles of a held request, logs each access.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        mem_ack_i = 1'b0;
        wcnt = 0;
      end else if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        wcnt = 0;
      end else if (stray_ack) begin
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'hBAD0_BAD0;
        stray_ack = 1'b0;
      end else if (mem_req_o) begin
        if (wcnt == mem_wait) begin
          mem_ack_i = 1'b1;
          acc_log.push_back('{mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o});
          if (mem_we_o) mem[mem_addr_o[9:2]] = merge(mem[mem_addr_o[9:2]], mem_wdata_o, mem_wstrb_o);
          else          mem_rdata_i = mem[mem_addr_o[9:2]];
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic drive_d(input txn_t t);
    dreq_i = 1'b1; dwe_i = t.we; daddr_i = t.addr; dwdata_i = t.wdata; dwstrb_i = t.wstrb;
  endtask

  task automatic drive_i(input txn_t t);
    ireq_i = 1'b1; iaddr_i = t.addr;
  endtask

  function automatic txn_t rd(input logic [31:0] a);
    return '{1'b0, a, 32'h0, 4'h0};
  endfunction

  // Runs d_plan and i_plan with both requesters held, against the model.
  task automatic run_traffic(input int w, output string got_order);
    exp_t  exp_q[$];
    exp_t  e;
    string exp_order;
    int    nd, ni, c, t, k, req_cycles, exp_t_k;
    bit    is_i;
    logic [31:0] exp_data, got_data;

    exp_order = ""; got_order = "";
    nd = 0; ni = 0; c = 0;
    while (nd < d_plan.size() || ni < i_plan.size()) begin
      if (nd < d_plan.size() && (c < int'(STARVE_LIMIT) || ni >= i_plan.size())) begin
        exp_q.push_back('{1'b0, d_plan[nd]});
        exp_order = {exp_order, "D"};
        c = (ni < i_plan.size()) ? c + 1 : 0;
        nd++;
      end else begin
        exp_q.push_back('{1'b1, i_plan[ni]});
        exp_order = {exp_order, "I"};
        c = 0;
        ni++;
      end
    end

    mem_wait = w;
    acc_log.delete();
    @(negedge clk);
    if (d_plan.size() > 0) drive_d(d_plan[0]);
    if (i_plan.size() > 0) drive_i(i_plan[0]);
    nd = 0; ni = 0; k = 0; t = 0; req_cycles = 0;
    while ((nd < d_plan.size() || ni < i_plan.size()) && t < TIMEOUT) begin
      @(negedge clk);
      t++;
      if (mem_req_o) req_cycles++;
      if (dready_o || iready_o) begin
        is_i = iready_o;
        if (is_i) got_order = {got_order, "I"};
        else      got_order = {got_order, "D"};
        n_cmp++;
        if (exp_q.size() == 0 || exp_q[0].is_i !== is_i || (dready_o && iready_o)) begin
          n_fail++;
          $display("FAIL grant_side: got iready=%0b dready=%0b, required is_i=%0b",
                   iready_o, dready_o, exp_q.size() ? exp_q[0].is_i : 1'bx);
        end else begin
          e = exp_q.pop_front();
          exp_t_k = (w + 2) + k * (w + 3);
          n_cmp++;
          if (t !== exp_t_k) begin
            n_fail++;
            $display("FAIL ready_time[%0d]: got cycle %0d, required %0d", k, t, exp_t_k);
          end
          n_cmp++;
          if (acc_log.size() == 0) begin
            n_fail++;
            $display("FAIL mem_access[%0d]: no memory access seen, required %h", k, e.t);
          end else if (acc_log[0] !== e.t) begin
            n_fail++;
            $display("FAIL mem_access[%0d]: got %h, required %h", k, acc_log[0], e.t);
          end
          if (acc_log.size() > 0) void'(acc_log.pop_front());
          if (is_i) begin
            exp_data = exp_mem[e.t.addr[9:2]];
            got_data = irdata_o;
          end else if (e.t.we) begin
            exp_data = exp_d_last;
            got_data = drdata_o;
            exp_mem[e.t.addr[9:2]] = merge(exp_mem[e.t.addr[9:2]], e.t.wdata, e.t.wstrb);
          end else begin
            exp_data = exp_mem[e.t.addr[9:2]];
            exp_d_last = exp_data;
            got_data = drdata_o;
          end
          n_cmp++;
          if (got_data !== exp_data) begin
            n_fail++;
            $display("FAIL rdata[%0d] side=%0b: got %h, required %h", k, is_i, got_data, exp_data);
          end
        end
        k++;
        if (dready_o) begin
          nd++;
          if (nd < d_plan.size()) drive_d(d_plan[nd]); else dreq_i = 1'b0;
        end
        if (iready_o) begin
          ni++;
          if (ni < i_plan.size()) drive_i(i_plan[ni]); else ireq_i = 1'b0;
        end
      end
    end
    dreq_i = 1'b0;
    ireq_i = 1'b0;
    n_cmp++;
    if (t >= TIMEOUT) begin
      n_fail++;
      $display("FAIL traffic_timeout: got %0d completions after %0d cycles, required %0d",
               k, t, d_plan.size() + i_plan.size());
    end
    n_cmp++;
    if (got_order != exp_order) begin
      n_fail++;
      $display("FAIL grant_order: got %s, required %s", got_order, exp_order);
    end
    n_cmp++;
    if (req_cycles !== k * (w + 1)) begin
      n_fail++;
      $display("FAIL mem_req_cycles: got %0d, required %0d", req_cycles, k * (w + 1));
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    string ord;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    #1;
    n_cmp++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mem_port: got req=%0b we=%0b addr=%h wdata=%h wstrb=%h, required all 0",
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o);
    end
    n_cmp++;
    if ({dready_o, iready_o, drdata_o, irdata_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_ready_data: got dready=%0b iready=%0b drdata=%h irdata=%h, required all 0",
               dready_o, iready_o, drdata_o, irdata_o);
    end
    // Abandon a long load mid-flight.
    mem_wait = 20;
    @(negedge clk);
    drive_d(rd(32'h80));
    repeat (3) @(negedge clk);
    n_cmp++;
    if (mem_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_before_reset: got mem_req=%0b, required 1", mem_req_o);
    end
    rst_ni = 1'b0;
    exp_d_last = '0;
    #1;
    n_cmp++;
    if (mem_req_o !== 1'b0 || dready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abandon: got mem_req=%0b dready=%0b, required 0 0", mem_req_o, dready_o);
    end
    dreq_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (mem_req_o !== 1'b0 || dready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL after_reset_idle: got mem_req=%0b dready=%0b, required 0 0", mem_req_o, dready_o);
      end
    end
    d_plan.delete(); i_plan.delete();
    d_plan.push_back(rd(32'h40));
    run_traffic(1, ord);
  endtask

  task automatic test_single_load();
    string ord;
    mem[32'h100 >> 2] = 32'hDEADBEEF;
    exp_mem[32'h100 >> 2] = 32'hDEADBEEF;
    d_plan.delete(); i_plan.delete();
    d_plan.push_back(rd(32'h100));
    run_traffic(3, ord);
  endtask

  task automatic test_store();
    string ord;
    d_plan.delete(); i_plan.delete();
    d_plan.push_back('{1'b1, 32'h100, 32'h12345678, 4'b0011});
    d_plan.push_back(rd(32'h100));
    run_traffic(2, ord);
    n_cmp++;
    if (exp_mem[32'h100 >> 2] !== 32'hDEAD5678 || drdata_o !== 32'hDEAD5678) begin
      n_fail++;
      $display("FAIL store_merge: got drdata %h, required DEAD5678", drdata_o);
    end
  endtask

  task automatic test_together();
    string ord;
    d_plan.delete(); i_plan.delete();
    d_plan.push_back(rd(32'h200));
    i_plan.push_back(rd(32'h300));
    run_traffic(0, ord);
  endtask

  task automatic test_starvation();
    string ord, want;
    d_plan.delete(); i_plan.delete();
    for (int n = 0; n < 6; n++) d_plan.push_back(rd(32'h10 + 32'(n) * 4));
    i_plan.push_back(rd(32'h380));
    i_plan.push_back(rd(32'h384));
    run_traffic(0, ord);
    want = "DDDDID";
    n_cmp++;
    if (ord.len() < 6 || ord.substr(0, 5) != want) begin
      n_fail++;
      $display("FAIL starve_prefix: got %s, required prefix %s", ord, want);
    end
  endtask

  task automatic test_stray_ack();
    @(negedge clk);
    stray_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (mem_req_o !== 1'b0 || dready_o !== 1'b0 || iready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL stray_ack: got req=%0b dready=%0b iready=%0b, required 0 0 0",
                 mem_req_o, dready_o, iready_o);
      end
    end
  endtask

  task automatic test_random();
    string ord;
    int nd_r, ni_r;
    for (int r = 0; r < 6; r++) begin
      d_plan.delete(); i_plan.delete();
      nd_r = $urandom_range(1, 7);
      ni_r = $urandom_range(0, 4);
      for (int n = 0; n < nd_r; n++)
        d_plan.push_back('{1'($urandom_range(0, 1)), {22'h0, 8'($urandom_range(0, 255)), 2'b00},
                           32'($urandom), 4'($urandom_range(0, 15))});
      for (int n = 0; n < ni_r; n++)
        i_plan.push_back(rd({22'h0, 8'($urandom_range(0, 255)), 2'b00}));
      run_traffic($urandom_range(0, 3), ord);
    end
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic test_perf();
    string ord;
    logic [31:0] d0, i0;
    d_plan.delete(); i_plan.delete();
    d_plan.push_back(rd(32'h20));
    i_plan.push_back(rd(32'h24));
    d0 = perf_dwait_o;
    i0 = perf_iwait_o;
    run_traffic(2, ord);
    n_cmp++;
    if (perf_iwait_o - i0 !== 32'd9) begin
      n_fail++;
      $display("FAIL perf_iwait: got delta %0d, required 9", perf_iwait_o - i0);
    end
    n_cmp++;
    if (perf_dwait_o - d0 !== 32'd4) begin
      n_fail++;
      $display("FAIL perf_dwait: got delta %0d, required 4", perf_dwait_o - d0);
    end
  endtask
`endif

  initial begin
    logic [31:0] v;
    rst_ni = 1'b0;
    ireq_i = 1'b0; iaddr_i = '0;
    dreq_i = 1'b0; dwe_i = 1'b0; daddr_i = '0; dwdata_i = '0; dwstrb_i = '0;
    for (int a = 0; a < 256; a++) begin
      v = $urandom;
      mem[a] = v;
      exp_mem[a] = v;
    end
    test_reset();
    test_single_load();
    test_store();
    test_together();
    test_starvation();
    test_stray_ack();
    test_random();
`ifdef MEM_ARB_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
